// File: rtl/risc_mem_pkg.sv
// Shared types and default widths for the RISC data-RAM arbiter.
package risc_mem_pkg;

  localparam int unsigned DEF_ADDR_W   = 6;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_MAX_HOLD = 4;

  // Owner tag carried alongside each RAM read so the data can be returned.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_LDR  = 2'b10
  } owner_t;

endpackage

// File: rtl/risc_rr_arbiter2.sv
// Two-way round-robin arbiter (CPU vs loader) with a CPU-streak bound.
module risc_rr_arbiter2
  import risc_mem_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic i_cpu_req,
  input  logic i_ldr_req,
  output logic o_cpu_gnt_c,
  output logic o_ldr_gnt_c
);

  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  owner_t             r_last_owner;
  owner_t             w_last_owner_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_nxt;
  logic               w_cpu_gnt;
  logic               w_ldr_gnt;

  // Arbitration state: last winner and CPU streak while the loader waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner <= OWN_LDR;
      r_hold_cnt   <= '0;
    end else begin
      r_last_owner <= w_last_owner_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  // Grant pick and next-state; grants are forced low while reset is held.
  always_comb begin
    w_cpu_gnt        = 1'b0;
    w_ldr_gnt        = 1'b0;
    w_last_owner_nxt = r_last_owner;
    w_hold_cnt_nxt   = r_hold_cnt;

    if (reset) begin
      if (i_cpu_req && i_ldr_req) begin
        if ((r_last_owner == OWN_CPU) || (r_hold_cnt >= HOLD_W'(MAX_HOLD))) begin
          w_ldr_gnt = 1'b1;
        end else begin
          w_cpu_gnt = 1'b1;
        end
      end else if (i_cpu_req) begin
        w_cpu_gnt = 1'b1;
      end else if (i_ldr_req) begin
        w_ldr_gnt = 1'b1;
      end
    end

    if (w_cpu_gnt) begin
      w_last_owner_nxt = OWN_CPU;
    end else if (w_ldr_gnt) begin
      w_last_owner_nxt = OWN_LDR;
    end

    if (!i_ldr_req || w_ldr_gnt) begin
      w_hold_cnt_nxt = '0;
    end else if (w_cpu_gnt && (r_hold_cnt < HOLD_W'(MAX_HOLD))) begin
      w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
    end
  end

  assign o_cpu_gnt_c = w_cpu_gnt;
  assign o_ldr_gnt_c = w_ldr_gnt;

endmodule

// File: rtl/risc_ram_arbiter.sv
// Shares the single-port data RAM between the CPU load/store path and the loader.
module risc_ram_arbiter
  import risc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              w_cpu_gnt;
  logic              w_ldr_gnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_ram_we;
  logic              r_ram_re;
  owner_t            r_tag;
  logic              r_cpu_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_ldr_rvalid;
  logic [DATA_W-1:0] r_ldr_rdata;

  risc_rr_arbiter2 #(
    .MAX_HOLD (MAX_HOLD)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .i_cpu_req   (cpu_req),
    .i_ldr_req   (ldr_req),
    .o_cpu_gnt_c (w_cpu_gnt),
    .o_ldr_gnt_c (w_ldr_gnt)
  );

  // Command register: launch the granted access; strobes drop when idle, addr/data hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_ram_re    <= 1'b0;
      r_tag       <= OWN_NONE;
    end else begin
      r_ram_we <= 1'b0;
      r_ram_re <= 1'b0;
      r_tag    <= OWN_NONE;
      if (w_cpu_gnt) begin
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
        r_ram_we    <= cpu_we;
        r_ram_re    <= ~cpu_we;
        r_tag       <= cpu_we ? OWN_NONE : OWN_CPU;
      end else if (w_ldr_gnt) begin
        r_ram_addr  <= ldr_addr;
        r_ram_wdata <= ldr_wdata;
        r_ram_we    <= ldr_we;
        r_ram_re    <= ~ldr_we;
        r_tag       <= ldr_we ? OWN_NONE : OWN_LDR;
      end
    end
  end

  // Read return: steer RAM data to the tagged owner; the other side holds its data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpu_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_ldr_rvalid <= 1'b0;
      r_ldr_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      r_ldr_rvalid <= 1'b0;
      if (r_tag == OWN_CPU) begin
        r_cpu_rvalid <= 1'b1;
        r_cpu_rdata  <= ram_rdata;
      end else if (r_tag == OWN_LDR) begin
        r_ldr_rvalid <= 1'b1;
        r_ldr_rdata  <= ram_rdata;
      end
    end
  end

  assign cpu_gnt    = w_cpu_gnt;
  assign ldr_gnt    = w_ldr_gnt;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign ram_we     = r_ram_we;
  assign ram_re     = r_ram_re;
  assign cpu_rvalid = r_cpu_rvalid;
  assign cpu_rdata  = r_cpu_rdata;
  assign ldr_rvalid = r_ldr_rvalid;
  assign ldr_rdata  = r_ldr_rdata;

endmodule

// File: tb/tb_risc_ram_arbiter.sv
// Directed bench for risc_ram_arbiter with a behavioural 64x16 RAM.
module tb_risc_ram_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [5:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        ldr_req;
  logic        ldr_we;
  logic [5:0]  ldr_addr;
  logic [15:0] ldr_wdata;
  logic        ldr_gnt;
  logic        ldr_rvalid;
  logic [15:0] ldr_rdata;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;

  logic [15:0] mem [64];
  int          n_checks;
  int          n_errors;

  risc_ram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .ldr_rdata  (ldr_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, read data presented while the read strobe is up.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

    // Reset with both requesters asserting: nothing may be granted or issued.
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd7;  cpu_wdata = 16'h1111;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 6'd9;  ldr_wdata = 16'h2222;
    cyc(); cyc();
    check("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
    check("rst_ldr_gnt",    32'(ldr_gnt),    32'd0);
    check("rst_ram_we",     32'(ram_we),     32'd0);
    check("rst_ram_re",     32'(ram_re),     32'd0);
    check("rst_ram_addr",   32'(ram_addr),   32'd0);
    check("rst_ram_wdata",  32'(ram_wdata),  32'd0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    check("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
    check("rst_ldr_rdata",  32'(ldr_rdata),  32'd0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    reset = 1'b1;
    cyc();

    // CPU-only: write 5 = BEEF then read it back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 16'hBEEF;
    #1;
    check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("wr_ldr_gnt", 32'(ldr_gnt), 32'd0);
    cyc();
    cpu_we = 1'b0; cpu_wdata = 16'h0000;
    check("wr_ram_we",    32'(ram_we),    32'd1);
    check("wr_ram_re",    32'(ram_re),    32'd0);
    check("wr_ram_addr",  32'(ram_addr),  32'd5);
    check("wr_ram_wdata", 32'(ram_wdata), 32'hBEEF);
    #1;
    check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cyc();
    cpu_req = 1'b0;
    check("rd_ram_re",   32'(ram_re),   32'd1);
    check("rd_ram_we",   32'(ram_we),   32'd0);
    check("rd_ram_addr", 32'(ram_addr), 32'd5);
    check("rd_early_rvalid", 32'(cpu_rvalid), 32'd0);
    cyc();
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd_cpu_rdata",  32'(cpu_rdata),  32'hBEEF);
    check("rd_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    check("rd_ldr_rdata",  32'(ldr_rdata),  32'd0);
    check("rd_idle_re",    32'(ram_re),     32'd0);
    cyc();
    check("rd_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

    // Ordering: last owner is CPU, so LDR write to 63 goes first and CPU reads it.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd63;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 6'd63; ldr_wdata = 16'h1234;
    #1;
    check("ord_ldr_gnt", 32'(ldr_gnt), 32'd1);
    check("ord_cpu_gnt", 32'(cpu_gnt), 32'd0);
    cyc();
    ldr_req = 1'b0;
    #1;
    check("ord_cpu_gnt2", 32'(cpu_gnt),   32'd1);
    check("ord_ram_we",   32'(ram_we),    32'd1);
    check("ord_ram_addr", 32'(ram_addr),  32'd63);
    check("ord_ram_wd",   32'(ram_wdata), 32'h1234);
    cyc();
    cpu_req = 1'b0;
    check("ord_ram_re", 32'(ram_re), 32'd1);
    cyc();
    check("ord_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("ord_cpu_rdata",  32'(cpu_rdata),  32'h1234);
    check("ord_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    cyc();

    // Reset asserted while a read is on the RAM pins: the read is dropped.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
    cyc();
    cpu_req = 1'b0;
    check("mid_ram_re", 32'(ram_re), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_re",     32'(ram_re),     32'd0);
    check("mid_rst_addr",   32'(ram_addr),   32'd0);
    check("mid_rst_rdata",  32'(cpu_rdata),  32'd0);
    check("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    check("mid_post_rvalid1", 32'(cpu_rvalid), 32'd0);
    cyc();
    check("mid_post_rvalid2", 32'(cpu_rvalid), 32'd0);

    // Tie from reset: CPU first, then strict alternation, one read per cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 6'd63;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tie_cpu_gnt%0d", i), 32'(cpu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("tie_ldr_gnt%0d", i), 32'(ldr_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i >= 1) begin
        check($sformatf("tie_ram_re%0d", i),   32'(ram_re),   32'd1);
        check($sformatf("tie_ram_addr%0d", i), 32'(ram_addr), (i % 2 == 1) ? 32'd5 : 32'd63);
      end
      if (i >= 2) begin
        if (i % 2 == 0) begin
          check($sformatf("tie_cpu_rv%0d", i), 32'(cpu_rvalid), 32'd1);
          check($sformatf("tie_cpu_rd%0d", i), 32'(cpu_rdata),  32'hBEEF);
          check($sformatf("tie_ldr_rv%0d", i), 32'(ldr_rvalid), 32'd0);
        end else begin
          check($sformatf("tie_ldr_rv%0d", i), 32'(ldr_rvalid), 32'd1);
          check($sformatf("tie_ldr_rd%0d", i), 32'(ldr_rdata),  32'h1234);
          check($sformatf("tie_cpu_rv%0d", i), 32'(cpu_rvalid), 32'd0);
        end
      end
      cyc();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    cyc(); cyc(); cyc();

    // Starvation: CPU streams reads, then LDR raises its request.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
    cyc(); cyc(); cyc();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 6'd63;
    #1;
    w = 0;
    while (!ldr_gnt && w < 8) begin
      cyc();
      w++;
    end
    check("starve_bound", 32'(w <= 4), 32'd1);
    check("starve_wait",  32'(w),      32'd0);
    check("starve_cpu_gnt", 32'(cpu_gnt), 32'd0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    cyc(); cyc(); cyc();

    // Withdraw: make LDR the last owner, then pulse ldr_req while CPU wins.
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 6'd10; ldr_wdata = 16'h5555;
    cyc();
    ldr_req = 1'b0;
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd20; cpu_wdata = 16'hAAAA;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 6'd30; ldr_wdata = 16'h7777;
    #1;
    check("wd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("wd_ldr_gnt", 32'(ldr_gnt), 32'd0);
    cyc();
    cpu_req = 1'b0; ldr_req = 1'b0;
    #1;
    check("wd_ram_we",   32'(ram_we),   32'd1);
    check("wd_ram_addr", 32'(ram_addr), 32'd20);
    check("wd_ldr_gnt2", 32'(ldr_gnt),  32'd0);
    cyc();
    check("wd_idle_we",    32'(ram_we),    32'd0);
    check("wd_idle_re",    32'(ram_re),    32'd0);
    check("wd_hold_addr",  32'(ram_addr),  32'd20);
    check("wd_hold_wdata", 32'(ram_wdata), 32'hAAAA);
    check("wd_mem30",      32'(mem[30]),   32'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
